// File: rtl/filter_window_mirror_if.sv
// Column-in / window-out bus of the mirrored filter window.
// The master side feeds columns and observes windows.
interface filter_window_mirror_if #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int IMG_WIDTH  = 640
);
    localparam int CW = $clog2(IMG_WIDTH);

    logic                                     in_valid;
    logic                                     in_ready;
    logic [PIX_BIT*MASK_WIDTH-1:0]            sngl_col_pixs_in;
    logic                                     out_valid;
    logic                                     out_sol;
    logic                                     out_eol;
    logic [CW-1:0]                            out_col;
    logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] masked_pixs_out;

    modport master (
        output in_valid, sngl_col_pixs_in,
        input  in_ready, out_valid, out_sol, out_eol, out_col, masked_pixs_out
    );

    modport slave (
        input  in_valid, sngl_col_pixs_in,
        output in_ready, out_valid, out_sol, out_eol, out_col, masked_pixs_out
    );
endinterface

// File: rtl/filter_window_mirror.sv
// Builds a MASK_WIDTH x MASK_WIDTH window per centre column from a column stream,
// mirroring without edge duplication at both row borders.
module filter_window_mirror #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int IMG_WIDTH  = 640
) (
    input  logic                  clk,
    input  logic                  reset,
    filter_window_mirror_if.slave bus
);
    localparam int R  = (MASK_WIDTH - 1) / 2;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int AW = $clog2(MASK_WIDTH);
    localparam int SW = $clog2(2 * MASK_WIDTH);
    localparam int DW = PIX_BIT * MASK_WIDTH;

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [CW-1:0] LAST_C    = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] R_C       = CW'(R);
    localparam logic [CW-1:0] RM1_C     = CW'(R - 1);
    localparam logic [CW-1:0] SELMAX_C  = CW'(MASK_WIDTH - 1);
    localparam logic [CW-1:0] FLBASE_C  = CW'(IMG_WIDTH - 1 - R);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] f_q, f_d;
    logic [DW-1:0] win_q [MASK_WIDTH];
    logic          out_valid_q, out_valid_d;
    logic          sol_q, sol_d;
    logic          eol_q, eol_d;
    logic [CW-1:0] col_q, col_d;
    logic          mode_q, mode_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          accept;

    assign bus.in_ready = (state_q != S_FLUSH);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        f_d         = f_q;
        out_valid_d = 1'b0;
        sol_d       = 1'b0;
        eol_d       = 1'b0;
        col_d       = col_q;
        mode_d      = mode_q;
        sel_d       = sel_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    n_d = n_q + 1'b1;
                    if (n_q == RM1_C) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    mode_d      = 1'b0;
                    // Only the first few columns of a row can need the left mirror.
                    sel_d       = (n_q >= SELMAX_C) ? SW'(MASK_WIDTH - 1) : SW'(n_q);
                    col_d       = n_q - R_C;
                    sol_d       = (n_q == R_C);
                    if (n_q == LAST_C) begin
                        state_d = S_FLUSH;
                        n_d     = '0;
                        f_d     = CW'(1);
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                out_valid_d = 1'b1;
                mode_d      = 1'b1;
                sel_d       = SW'(f_q);
                col_d       = FLBASE_C + f_q;
                eol_d       = (f_q == R_C);
                if (f_q == R_C) begin
                    state_d = S_FILL;
                    f_d     = '0;
                end else begin
                    f_d = f_q + 1'b1;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FILL;
            n_q         <= '0;
            f_q         <= '0;
            out_valid_q <= 1'b0;
            sol_q       <= 1'b0;
            eol_q       <= 1'b0;
            col_q       <= '0;
            mode_q      <= 1'b0;
            sel_q       <= '0;
            for (int k = 0; k < MASK_WIDTH; k++) win_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
            sol_q       <= sol_d;
            eol_q       <= eol_d;
            col_q       <= col_d;
            mode_q      <= mode_d;
            sel_q       <= sel_d;
            if (accept) begin
                win_q[0] <= bus.sngl_col_pixs_in;
                for (int k = 1; k < MASK_WIDTH; k++) win_q[k] <= win_q[k-1];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sol   = sol_q;
    assign bus.out_eol   = eol_q;
    assign bus.out_col   = col_q;

    // Left mirror folds about the newest column index, right mirror about f.
    for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_col
        localparam logic [SW-1:0] I_C = SW'(gi);
        logic [SW-1:0] idx;
        logic [DW-1:0] col_w;
        always_comb begin
            if (mode_q)            idx = (I_C >= sel_q) ? (I_C - sel_q) : (sel_q - I_C);
            else if (I_C <= sel_q) idx = I_C;
            else                   idx = (sel_q << 1) - I_C;
            col_w = win_q[idx[AW-1:0]];
        end
        for (genvar gj = 0; gj < MASK_WIDTH; gj++) begin : g_row
            assign bus.masked_pixs_out[(gj*MASK_WIDTH+gi)*PIX_BIT +: PIX_BIT] =
                col_w[gj*PIX_BIT +: PIX_BIT];
        end
    end
endmodule

// File: tb/tb_filter_window_mirror.sv
// Scoreboard bench: two instances (3x3 and 7x7 masks, 8-pixel rows) fed with
// pixel(row j, col x) = 16j+x; expected windows come from an explicit mirror model.
module tb_filter_window_mirror;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    filter_window_mirror_if #(.PIX_BIT(8), .MASK_WIDTH(3), .IMG_WIDTH(W)) bus3 ();
    filter_window_mirror_if #(.PIX_BIT(8), .MASK_WIDTH(7), .IMG_WIDTH(W)) bus7 ();

    filter_window_mirror #(.PIX_BIT(8), .MASK_WIDTH(3), .IMG_WIDTH(W)) dut3 (
        .clk(clk), .reset(rst_n), .bus(bus3));
    filter_window_mirror #(.PIX_BIT(8), .MASK_WIDTH(7), .IMG_WIDTH(W)) dut7 (
        .clk(clk), .reset(rst_n), .bus(bus7));

    typedef struct {
        int           col;
        logic         sol;
        logic         eol;
        logic [391:0] win;
        longint       due;
    } exp_t;

    exp_t   q3[$];
    exp_t   q7[$];
    int     tests = 0;
    int     fails = 0;
    int     pulses3 = 0;
    int     pulses7 = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [55:0] col_data(input int m, input int x);
        logic [55:0] d = '0;
        for (int j = 0; j < m; j++) d[j*8 +: 8] = 8'(16*j + x);
        return d;
    endfunction

    function automatic logic [391:0] exp_win(input int m, input int c);
        logic [391:0] w = '0;
        int r = (m - 1) / 2;
        for (int j = 0; j < m; j++) begin
            for (int i = 0; i < m; i++) begin
                int x = c + r - i;
                if (x < 0) x = -x;
                if (x > W - 1) x = 2*(W - 1) - x;
                w[(j*m + i)*8 +: 8] = 8'(16*j + x);
            end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [391:0] got, input logic [391:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int k, input int x);
        int m = (k == 0) ? 3 : 7;
        int r = (m - 1) / 2;
        for (int f = 0; f <= r; f++) begin
            int c = x - r + f;
            exp_t e;
            if (f > 0 && x != W - 1) break;
            if (c < 0) continue;
            e.col = c;
            e.sol = (c == 0);
            e.eol = (c == W - 1);
            e.win = exp_win(m, c);
            e.due = cyc + 1 + f;
            if (k == 0) q3.push_back(e); else q7.push_back(e);
        end
    endtask

    task automatic check_out(input int k, input logic sol, input logic eol,
                             input int col, input logic [391:0] win);
        exp_t e;
        int   sz = (k == 0) ? q3.size() : q7.size();
        chk($sformatf("expected_pending_k%0d", k), 392'(sz != 0), 392'(1));
        if (sz == 0) return;
        if (k == 0) begin e = q3.pop_front(); pulses3++; end
        else begin e = q7.pop_front(); pulses7++; end
        chk($sformatf("latency_k%0d_c%0d", k, e.col), 392'(cyc), 392'(e.due));
        chk($sformatf("out_col_k%0d_c%0d", k, e.col), 392'(col), 392'(e.col));
        chk($sformatf("out_sol_k%0d_c%0d", k, e.col), 392'(sol), 392'(e.sol));
        chk($sformatf("out_eol_k%0d_c%0d", k, e.col), 392'(eol), 392'(e.eol));
        chk($sformatf("window_k%0d_c%0d", k, e.col), win, e.win);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus3.out_valid)
                check_out(0, bus3.out_sol, bus3.out_eol, int'(bus3.out_col),
                          392'(bus3.masked_pixs_out));
            if (bus7.out_valid)
                check_out(1, bus7.out_sol, bus7.out_eol, int'(bus7.out_col),
                          bus7.masked_pixs_out);
        end
    end

    task automatic send(input int k, input int x);
        int   t = 0;
        logic rdy;
        if (k == 0) begin bus3.in_valid = 1'b1; bus3.sngl_col_pixs_in = 24'(col_data(3, x)); end
        else begin bus7.in_valid = 1'b1; bus7.sngl_col_pixs_in = col_data(7, x); end
        rdy = (k == 0) ? bus3.in_ready : bus7.in_ready;
        while (!rdy && t < 20) begin
            @(negedge clk);
            t++;
            rdy = (k == 0) ? bus3.in_ready : bus7.in_ready;
        end
        chk($sformatf("ready_wait_k%0d_x%0d", k, x), 392'(rdy), 392'(1));
        push_exp(k, x);
        @(negedge clk);
    endtask

    task automatic idle(input int k, input int n);
        if (k == 0) bus3.in_valid = 1'b0; else bus7.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic row(input int k, input int gapmax);
        for (int x = 0; x < W; x++) begin
            send(k, x);
            if (gapmax > 0) idle(k, $urandom_range(0, gapmax));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid3"}, 392'(bus3.out_valid), 392'(0));
        chk({tag, "_sol3"},   392'(bus3.out_sol), 392'(0));
        chk({tag, "_eol3"},   392'(bus3.out_eol), 392'(0));
        chk({tag, "_col3"},   392'(bus3.out_col), 392'(0));
        chk({tag, "_win3"},   392'(bus3.masked_pixs_out), 392'(0));
        chk({tag, "_ready3"}, 392'(bus3.in_ready), 392'(1));
        chk({tag, "_valid7"}, 392'(bus7.out_valid), 392'(0));
        chk({tag, "_win7"},   bus7.masked_pixs_out, 392'(0));
        chk({tag, "_ready7"}, 392'(bus7.in_ready), 392'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus3.in_valid = 1'b0; bus3.sngl_col_pixs_in = '0;
        bus7.in_valid = 1'b0; bus7.sngl_col_pixs_in = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Full row with in_valid held high, then right-border stall timing.
        pulses3 = 0;
        for (int x = 0; x < W - 1; x++) send(0, x);
        send(0, W - 1);
        chk("flush_ready_low3", 392'(bus3.in_ready), 392'(0));
        idle(0, 1);
        chk("flush_ready_back3", 392'(bus3.in_ready), 392'(1));
        idle(0, 2);
        chk("pulses_row3", 392'(pulses3), 392'(W));
        chk("drained_row3", 392'(q3.size()), 392'(0));

        // Two back-to-back rows with random input gaps.
        pulses3 = 0;
        row(0, 2);
        row(0, 2);
        idle(0, 4);
        chk("pulses_gap_rows3", 392'(pulses3), 392'(2*W));
        chk("drained_gap_rows3", 392'(q3.size()), 392'(0));

        // Wide mask: three-cycle flush.
        pulses7 = 0;
        for (int x = 0; x < W; x++) send(1, x);
        idle(1, 0);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("flush_ready_low7_s%0d", s), 392'(bus7.in_ready), 392'(0));
            @(negedge clk);
        end
        chk("flush_ready_back7", 392'(bus7.in_ready), 392'(1));
        idle(1, 2);
        chk("pulses_row7", 392'(pulses7), 392'(W));
        chk("drained_row7", 392'(q7.size()), 392'(0));

        // Reset in the middle of a row, after column 5.
        for (int x = 0; x < 6; x++) send(0, x);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrow_reset");
        q3.delete();
        q7.delete();
        idle(0, 1);
        rst_n = 1'b1;
        @(negedge clk);
        pulses3 = 0;
        send(0, 0);
        chk("restart_no_out_after_1", 392'(pulses3), 392'(0));
        for (int x = 1; x < W; x++) send(0, x);
        idle(0, 3);
        chk("pulses_restart3", 392'(pulses3), 392'(W));
        chk("drained_restart3", 392'(q3.size()), 392'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/filter_window_mirror.md
# filter_window_mirror

Parametrised successor to the fixed 7×7 filter mask window. It turns a stream of image columns into a MASK_WIDTH×MASK_WIDTH pixel window around each centre column. The mirror-without-duplication border scheme is built in: this block generates its own border selects internally, where the earlier window needed externally driven ones. It sits between the line buffers, which supply one MASK_WIDTH-pixel column per accepted beat, and the filter function, which consumes one full window per output beat. It adds a valid/ready input handshake, per-row column counting and an automatic right-border flush.

## Interface
- PIX_BIT, 8, bits per pixel.
- MASK_WIDTH, 7, window side. Must be odd and ≥3; R = (MASK_WIDTH-1)/2.
- IMG_WIDTH, 640, pixels per image row. Must be ≥ MASK_WIDTH; CW = $clog2(IMG_WIDTH).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  a column is present on sngl_col_pixs_in.
- in_ready  out  1  block accepts a column this cycle. A column is accepted when in_valid and in_ready are both 1 at a clk edge.
- sngl_col_pixs_in  in  PIX_BIT*MASK_WIDTH  one image column. Mask row j occupies bits [PIX_BIT*(j+1)-1 : PIX_BIT*j].
- out_valid  out  1  masked_pixs_out holds a valid window. Single-cycle pulse per window; there is no backpressure.
- out_sol  out  1  window is centred on column 0 (qualified by out_valid).
- out_eol  out  1  window is centred on column IMG_WIDTH-1 (qualified by out_valid).
- out_col  out  CW  centre column of the current window.
- masked_pixs_out  out  PIX_BIT*MASK_WIDTH²  output window.
  - Row j, window column i occupies bits [(j*MASK_WIDTH+i+1)*PIX_BIT-1 : (j*MASK_WIDTH+i)*PIX_BIT].
  - It holds the image pixel at column c+R-i, after mirroring: i=0 is the rightmost (newest) column.

## Operation
- Window storage: MASK_WIDTH column registers win[0..MASK_WIDTH-1]. On each accepted column, win[0] takes the input and win[k] takes win[k-1]. No shift occurs at any other time.
- Column counter n (CW bits) counts accepted columns within the current row, 0..IMG_WIDTH-1. Flush counter f counts 0..R.
- States:
  - FILL: in_ready=1. Accepted columns 0..R-1 produce no output. Accepting column R-1 moves to RUN.
  - RUN: in_ready=1. Accepting column n (R ≤ n ≤ IMG_WIDTH-1) produces a window centred on c=n-R. Accepting n=IMG_WIDTH-1 moves to FLUSH with f=1.
  - FLUSH: in_ready=0, window registers frozen. Every cycle produces the window centred on c=IMG_WIDTH-1-R+f, then f increments. After f=R has been emitted, go to FILL with n=0.
- Output mux: window column i is read from win[idx(i)], with mode and select registered together with out_valid.
  - RUN, newest column n: idx = n - |n-i|. This mirrors about column 0 when i>n; otherwise idx=i.
  - FLUSH step f: idx = |i-f|. This mirrors about column IMG_WIDTH-1.
- Mirror rule, no duplication: a missing column -x maps to x; a missing column IMG_WIDTH-1+x maps to IMG_WIDTH-1-x. The edge column itself is never repeated.
- All MASK_WIDTH rows use the same idx; rows are independent.
- Rows follow one another with no gap other than the R FLUSH cycles. The block keeps no frame state; vertical borders are the line buffers' responsibility.
- in_valid while in_ready=0 is ignored; the upstream stage must hold its data.

## Timing
- Reset (reset=0, async): state FILL, n=0, f=0, all win registers 0, out_valid=0, out_sol=0, out_eol=0, out_col=0, masked_pixs_out=0, in_ready=1 as soon as reset releases.
- Latency: the window for an accepted column appears, with out_valid=1, in the cycle immediately after the accepting edge.
- Per row: IMG_WIDTH accepts followed by R stall cycles give IMG_WIDTH windows. The minimum period is IMG_WIDTH+R cycles.
- Centre column IMG_WIDTH-1-R comes from the last RUN accept. The final R windows come from the consecutive FLUSH cycles, with out_valid held at 1 throughout.
- in_ready is combinational from state only. It drops in the cycle after column IMG_WIDTH-1 is accepted and returns after the last FLUSH edge.
- Reset asserted mid-row or mid-FLUSH aborts the row immediately. After release, the next accepted column is treated as column 0.

## Test plan
Common setup: MASK_WIDTH=3, IMG_WIDTH=8, pixel(row j, col x) = 16j+x.
1. Full row, in_valid held at 1:
   - First out_valid comes one cycle after column 1 is accepted, with out_col=0, out_sol=1.
   - Row 0 window reads {1,0,1}; row 2 reads {33,32,33}.
2. Right border:
   - out_col=7 with out_eol=1; row 0 reads {6,7,6}.
   - in_ready=0 for exactly 1 cycle after column 7 is accepted.
3. Interior: window at out_col=4 row 1 reads {21,20,19}; 8 out_valid pulses per row, col 0..7 in order.
4. Back-to-back rows with random in_valid gaps: window content is identical to scenario 1, with no output during gaps.
5. MASK_WIDTH=7, IMG_WIDTH=8:
   - out_col=0 row 0 reads {3,2,1,0,1,2,3}; out_col=7 row 0 reads {4,5,6,7,6,5,4}.
   - FLUSH lasts 3 cycles.
6. Assert reset while in FLUSH after col 5 of the following row… i.e. mid-row at column 5:
   - All outputs go to 0 and in_ready=1 immediately.
   - The next row restarts with out_col=0 after 2 accepts.
